addr_seq_gen: RTL and testbench
===============================

# addr_seq_gen

Parametrised address sequencer for the findMax datapath and later scan-style circuits. It emits a run of `count` addresses from `start_addr`, stepping by a programmable `stride` up or down. Each address goes out over a valid/ready handshake to the memory-read stage. It signals completion with a one-cycle `done` pulse, and its widths are decoupled so it can drive any memory depth.

## Interface
- `ADDR_W`, 16, address width; all address arithmetic is modulo 2^ADDR_W.
- `CNT_W`, 8, width of the run-length field; maximum run is 2^CNT_W − 1 addresses.
- `STRIDE_W`, 4, width of the unsigned stride field.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- `start`  in  1  launch request; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first address of the run; captured on an accepted `start`.
- `count`  in  CNT_W  number of addresses to emit; captured on an accepted `start`.
- `stride`  in  STRIDE_W  step magnitude; captured on an accepted `start`. 0 is legal and repeats `start_addr`.
- `dir`  in  1  0 = increment, 1 = decrement; captured on an accepted `start`.
- `addr`  out  ADDR_W  current address; meaningful while `addr_valid` is high.
- `addr_valid`  out  1  `addr` is offered to the consumer.
- `addr_ready`  in  1  consumer accepts `addr` this cycle.
- `last`  out  1  high with `addr_valid` on the final address of the run.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse after the run completes.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `start`=1 and `count`≠0 → capture all inputs, load `addr`=`start_addr` and `remaining`=`count`, go to RUN.
- IDLE: `start`=1 and `count`=0 → go to DONE directly; no address is emitted.
- RUN: `addr_valid`=1.
  - On handshake (`addr_valid`&&`addr_ready`) with `remaining`>1: `addr` ← `addr` ± `stride` (zero-extended, wraps modulo 2^ADDR_W), `remaining` ← `remaining`−1.
  - On handshake with `remaining`=1: go to DONE.
- DONE: `done`=1 and `addr_valid`=0 for exactly one cycle, then IDLE.
- `start` in RUN or DONE is ignored and is not queued.
- Captured `stride`/`dir` are used for the whole run; input changes mid-run have no effect.
- `last` = RUN && `remaining`==1.

## Timing
- Reset values: `addr`=0, `addr_valid`=0, `last`=0, `busy`=0, `done`=0, `remaining`=0, state IDLE.
- All outputs are registered or decoded from registered state only; no combinational path from `addr_ready` or `start` to any output.
- `start` accepted at edge E0 → `addr_valid`=1 with `addr`=`start_addr` in the cycle after E0.
- Throughput with `addr_ready` held high: one address per cycle.
- Run of N addresses with no backpressure:
  - handshakes in cycles 1..N;
  - `done` in cycle N+1;
  - IDLE in cycle N+2; earliest next `start` is sampled there.
- Backpressure: while `addr_valid`&&!`addr_ready`, `addr`, `last` and `remaining` hold stable.
- Zero-count start: `done` in the cycle after E0, and `addr_valid` never rises.
- Reset asserted mid-run: all outputs drop to reset values asynchronously, the run is abandoned, and no `done` is produced.

## Structure
- Shared package `addr_seq_pkg`:
  - state typedef (IDLE/RUN/DONE);
  - direction constants `DIR_UP`=0, `DIR_DOWN`=1.
- One sub-module: `addr_step`, a combinational ADDR_W add/subtract of the zero-extended stride selected by `dir`. It is reused by later multi-channel sequencers.
- Control FSM and counters stay in `addr_seq_gen`.

## Test plan
- `start_addr`=8, `count`=5, `stride`=1, `dir`=0, ready high → `addr` 8,9,10,11,12 in cycles 1–5, `last` only with 12, `done` in cycle 6.
- `start_addr`=1, `count`=3, `stride`=2, `dir`=1 → `addr` 0x0001, 0xFFFF, 0xFFFD (wrap-around), then `done`.
- `start_addr`=10, `count`=2, `addr_ready` low for 3 cycles on the first address → `addr` holds at 10 with `addr_valid` high; then 10, 12 (stride 2), then `done`.
- `count`=0 → `done` pulses the cycle after `start`; `addr_valid` stays 0.
- `start`=1 at cycle 2 of a run with `start_addr`=100 → ignored; the original sequence completes unchanged, with exactly one `done`.
- `reset` asserted after 2 of 5 handshakes → outputs zero immediately, no `done`. A fresh `start` after release runs from its own `start_addr`.

Source files
------------

// File: rtl/addr_seq_pkg.sv
// Shared types and constants for the address sequencer family.
// Imported by the sequencer control and its stepping datapath.
package addr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/addr_step.sv
// Combinational next-address step: addr +/- zero-extended stride.
// Wraps modulo 2^ADDR_W; shared with multi-channel sequencers.
module addr_step
    import addr_seq_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int STRIDE_W = 4
) (
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [STRIDE_W-1:0] stride_i,
    input  logic                dir_i,
    output logic [ADDR_W-1:0]   addr_o
);

    logic [ADDR_W-1:0] step;

    assign step   = ADDR_W'(stride_i);
    assign addr_o = (dir_i == DIR_DOWN) ? addr_i - step
                                        : addr_i + step;

endmodule

// File: rtl/addr_seq_gen.sv
// Address sequencer: emits count addresses from start_addr over
// a valid/ready handshake, then pulses done for one cycle.
module addr_seq_gen
    import addr_seq_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 8,
    parameter int STRIDE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [CNT_W-1:0]    count,
    input  logic [STRIDE_W-1:0] stride,
    input  logic                dir,
    output logic [ADDR_W-1:0]   addr,
    output logic                addr_valid,
    input  logic                addr_ready,
    output logic                last,
    output logic                busy,
    output logic                done
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic                dir_q, dir_d;
    logic [ADDR_W-1:0]   addr_nxt;

    addr_step #(
        .ADDR_W   (ADDR_W),
        .STRIDE_W (STRIDE_W)
    ) u_step (
        .addr_i   (addr_q),
        .stride_i (stride_q),
        .dir_i    (dir_q),
        .addr_o   (addr_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            stride_q <= '0;
            dir_q    <= DIR_UP;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            stride_q <= stride_d;
            dir_q    <= dir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        stride_d = stride_q;
        dir_d    = dir_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d  = RUN;
                        addr_d   = start_addr;
                        rem_d    = count;
                        stride_d = stride;
                        dir_d    = dir;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (addr_ready) begin
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                        rem_d   = '0;
                    end else begin
                        addr_d = addr_nxt;
                        rem_d  = rem_q - CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only; addr_ready never reaches them.
    always_comb begin
        addr_valid = 1'b0;
        last       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            RUN: begin
                addr_valid = 1'b1;
                last       = (rem_q == CNT_W'(1));
                busy       = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign addr = addr_q;

endmodule

// File: tb/tb_addr_seq_gen.sv
// Scoreboard bench for addr_seq_gen: directed runs push expected
// addresses; a negedge monitor pops and compares on each handshake.
module tb_addr_seq_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] start_addr;
    logic [7:0]  count;
    logic [3:0]  stride;
    logic        dir;
    logic [15:0] addr;
    logic        addr_valid;
    logic        addr_ready;
    logic        last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int valid_cnt = 0;

    logic [16:0] exp_q[$];

    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr  = '0;
    logic        prev_last  = 1'b0;

    always #5 clk = ~clk;

    addr_seq_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .stride     (stride),
        .dir        (dir),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .last       (last),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: compares every handshake against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall && addr_valid) begin
                chk("stall_addr_hold", {16'h0, addr}, {16'h0, prev_addr});
                chk("stall_last_hold", {31'h0, last}, {31'h0, prev_last});
            end
            if (addr_valid) valid_cnt++;
            if (addr_valid && addr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_addr", {16'h0, addr}, 32'hDEAD);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    chk("addr_last", {15'h0, last, addr}, {15'h0, e});
                end
            end
            if (done) done_cnt++;
            prev_stall = addr_valid && !addr_ready;
            prev_addr  = addr;
            prev_last  = last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push(input logic [15:0] a, input logic l);
        exp_q.push_back({l, a});
    endtask

    task automatic launch(input logic [15:0] sa, input logic [7:0] c,
                          input logic [3:0] s, input logic d);
        start_addr = sa;
        count      = c;
        stride     = s;
        dir        = d;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input int exp, input string nm);
        int n;
        n = -1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                n = i;
                break;
            end
            @(posedge clk); #1;
        end
        chk(nm, n, exp);
        chk({nm, "_valid_low"}, {31'h0, addr_valid}, 32'h0);
    endtask

    task automatic idle_gap(input string nm);
        @(posedge clk); #1;
        chk({nm, "_idle_busy"}, {31'h0, busy}, 32'h0);
        chk({nm, "_idle_done"}, {31'h0, done}, 32'h0);
        chk({nm, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int dc0;
        int vc0;
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        stride     = '0;
        dir        = 1'b0;
        addr_ready = 1'b1;
        #2;
        chk("rst_addr",  {16'h0, addr}, 32'h0);
        chk("rst_valid", {31'h0, addr_valid}, 32'h0);
        chk("rst_last",  {31'h0, last}, 32'h0);
        chk("rst_busy",  {31'h0, busy}, 32'h0);
        chk("rst_done",  {31'h0, done}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Incrementing run of 5
        push(16'd8, 1'b0); push(16'd9, 1'b0); push(16'd10, 1'b0);
        push(16'd11, 1'b0); push(16'd12, 1'b1);
        launch(16'd8, 8'd5, 4'd1, 1'b0);
        chk("t1_first_valid", {31'h0, addr_valid}, 32'h1);
        chk("t1_first_addr", {16'h0, addr}, 32'd8);
        wait_done(5, "t1_done_cycle");
        idle_gap("t1");

        // Decrementing with wrap-around
        push(16'h0001, 1'b0); push(16'hFFFF, 1'b0); push(16'hFFFD, 1'b1);
        launch(16'h0001, 8'd3, 4'd2, 1'b1);
        wait_done(3, "t2_done_cycle");
        idle_gap("t2");

        // Backpressure on the first address
        addr_ready = 1'b0;
        push(16'd10, 1'b0); push(16'd12, 1'b1);
        launch(16'd10, 8'd2, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_valid", {31'h0, addr_valid}, 32'h1);
            chk("t3_stall_addr", {16'h0, addr}, 32'd10);
            @(posedge clk); #1;
        end
        addr_ready = 1'b1;
        wait_done(2, "t3_done_cycle");
        idle_gap("t3");

        // Zero-length run
        vc0 = valid_cnt;
        dc0 = done_cnt;
        launch(16'h1234, 8'd0, 4'd1, 1'b0);
        wait_done(0, "t4_done_cycle");
        idle_gap("t4");
        chk("t4_no_valid", valid_cnt - vc0, 0);
        chk("t4_one_done", done_cnt - dc0, 1);

        // start during a run is ignored
        dc0 = done_cnt;
        push(16'h20, 1'b0); push(16'h23, 1'b0); push(16'h26, 1'b0);
        push(16'h29, 1'b0); push(16'h2C, 1'b1);
        launch(16'h20, 8'd5, 4'd3, 1'b0);
        @(posedge clk); #1;
        start_addr = 16'd100;
        count      = 8'd7;
        stride     = 4'd9;
        dir        = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        wait_done(3, "t5_done_cycle");
        idle_gap("t5");
        repeat (2) @(posedge clk);
        #1;
        chk("t5_one_done", done_cnt - dc0, 1);
        chk("t5_still_idle", {31'h0, busy}, 32'h0);

        // Reset mid-run, then a fresh run
        dc0 = done_cnt;
        push(16'h40, 1'b0); push(16'h41, 1'b0);
        launch(16'h40, 8'd5, 4'd1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_addr",  {16'h0, addr}, 32'h0);
        chk("t6_rst_valid", {31'h0, addr_valid}, 32'h0);
        chk("t6_rst_last",  {31'h0, last}, 32'h0);
        chk("t6_rst_busy",  {31'h0, busy}, 32'h0);
        chk("t6_drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("t6_no_done", done_cnt - dc0, 0);
        @(posedge clk); #1;
        push(16'h200, 1'b0); push(16'h204, 1'b1);
        launch(16'h200, 8'd2, 4'd4, 1'b0);
        chk("t6_fresh_addr", {16'h0, addr}, 32'h200);
        wait_done(2, "t6_done_cycle");
        idle_gap("t6");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
